// File: rtl/rv_pipe_pkg.sv
// Shared types and encodings for the RISC-V pipeline hazard controller.
package rv_pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pipe_freeze;
  } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if import rv_pipe_pkg::*; #(
  parameter int CNT_W = 32
);
  logic             idex_memread;
  logic [REG_W-1:0] idex_rd;
  logic [REG_W-1:0] ifid_rs1;
  logic [REG_W-1:0] ifid_rs2;
  logic             exmem_branch;
  logic             exmem_zero;
  logic             exmem_res_lsb;
  logic [2:0]       exmem_funct3;
  // Memory handshake: an access is outstanding while exmem_memacc is high;
  // it completes in the cycle dmem_ready is high, otherwise the pipe freezes.
  logic             exmem_memacc;
  logic             dmem_ready;
  logic             pc_write;
  logic             pc_src;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             pipe_freeze;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  state_t           state;

  modport master (
    output idex_memread, idex_rd, ifid_rs1, ifid_rs2, exmem_branch, exmem_zero,
           exmem_res_lsb, exmem_funct3, exmem_memacc, dmem_ready,
    input  pc_write, pc_src, ifid_write, idex_bubble, ifid_flush, idex_flush,
           exmem_flush, pipe_freeze, mem_err, stall_cycles, state
  );

  modport slave (
    input  idex_memread, idex_rd, ifid_rs1, ifid_rs2, exmem_branch, exmem_zero,
           exmem_res_lsb, exmem_funct3, exmem_memacc, dmem_ready,
    output pc_write, pc_src, ifid_write, idex_bubble, ifid_flush, idex_flush,
           exmem_flush, pipe_freeze, mem_err, stall_cycles, state
  );
endinterface

// File: rtl/branch_resolve.sv
// Branch outcome from the EX/MEM stage flags and funct3.
module branch_resolve import rv_pipe_pkg::*; (
  input  logic       branch,
  input  logic       zero,
  input  logic       res_lsb,
  input  logic [2:0] funct3,
  output logic       taken
);
  logic cond;

  // res_lsb carries the SLT/SLTU result computed by the ALU for this branch.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:           cond = zero;
      F3_BNE:           cond = !zero;
      F3_BLT, F3_BLTU:  cond = res_lsb;
      F3_BGE, F3_BGEU:  cond = !res_lsb;
      default:          cond = 1'b0;
    endcase
  end

  assign taken = branch && cond;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: load-use stalls, branch flushes, data-memory freeze,
// sticky memory timeout and a saturating stall-cycle counter.
module pipeline_hazard_ctrl import rv_pipe_pkg::*; #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int CNT_W           = 32
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam logic [2:0]  LU_RELOAD = 3'(LU_STALL_CYCLES - 1);
  localparam logic [15:0] TIMEOUT   = 16'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d, wait_inc;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_q;
  ctrl_t            ctrl;
  logic             branch_taken, lu_hazard, mem_wait;

  branch_resolve u_branch_resolve (
    .branch  (bus.exmem_branch),
    .zero    (bus.exmem_zero),
    .res_lsb (bus.exmem_res_lsb),
    .funct3  (bus.exmem_funct3),
    .taken   (branch_taken)
  );

  assign lu_hazard = bus.idex_memread && (bus.idex_rd != '0) &&
                     ((bus.idex_rd == bus.ifid_rs1) || (bus.idex_rd == bus.ifid_rs2));
  assign mem_wait  = bus.exmem_memacc && !bus.dmem_ready;
  assign wait_inc  = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    lu_cnt_d   = lu_cnt_q;
    wait_cnt_d = wait_cnt_q;
    ctrl       = '0;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          ctrl.pipe_freeze = 1'b1;
          wait_cnt_d       = 16'd1;
          state_d          = MEM_WAIT;
        end else if (branch_taken) begin
          ctrl.pc_src      = 1'b1;
          ctrl.pc_write    = 1'b1;
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_flush  = 1'b1;
          ctrl.exmem_flush = 1'b1;
        end else if (lu_hazard) begin
          ctrl.idex_bubble = 1'b1;
          if (LU_STALL_CYCLES > 1) begin
            lu_cnt_d = LU_RELOAD;
            state_d  = LU_STALL;
          end
        end else begin
          ctrl.pc_write   = 1'b1;
          ctrl.ifid_write = 1'b1;
        end
      end
      LU_STALL: begin
        if (mem_wait) begin
          ctrl.pipe_freeze = 1'b1;
          wait_cnt_d       = 16'd1;
          state_d          = MEM_WAIT;
        end else if (branch_taken) begin
          ctrl.pc_src      = 1'b1;
          ctrl.pc_write    = 1'b1;
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_flush  = 1'b1;
          ctrl.exmem_flush = 1'b1;
          lu_cnt_d         = 3'd0;
          state_d          = RUN;
        end else begin
          ctrl.idex_bubble = 1'b1;
          lu_cnt_d         = (lu_cnt_q != 3'd0) ? lu_cnt_q - 3'd1 : 3'd0;
          if (lu_cnt_q <= 3'd1) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          ctrl.pipe_freeze = 1'b1;
          wait_cnt_d       = wait_inc;
        end else if (lu_cnt_q != 3'd0) begin
          // Interrupted load-use stall resumes; the dependent instruction is still held.
          ctrl.idex_bubble = 1'b1;
          state_d          = LU_STALL;
        end else begin
          ctrl.pc_write   = 1'b1;
          ctrl.ifid_write = 1'b1;
          state_d         = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (reset) ctrl = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      lu_cnt_q   <= 3'd0;
      wait_cnt_q <= 16'd0;
      mem_err_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      lu_cnt_q   <= lu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      if (ctrl.pipe_freeze && (wait_cnt_d == TIMEOUT)) mem_err_q <= 1'b1;
      if (!ctrl.pc_write && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.pc_write     = ctrl.pc_write;
  assign bus.pc_src       = ctrl.pc_src;
  assign bus.ifid_write   = ctrl.ifid_write;
  assign bus.idex_bubble  = ctrl.idex_bubble;
  assign bus.ifid_flush   = ctrl.ifid_flush;
  assign bus.idex_flush   = ctrl.idex_flush;
  assign bus.exmem_flush  = ctrl.exmem_flush;
  assign bus.pipe_freeze  = ctrl.pipe_freeze;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cycles = stall_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances (1-cycle and 3-cycle
// load-use stall), expected responses queued by the driver, checked by a monitor.
module tb_pipeline_hazard_ctrl;
  import rv_pipe_pkg::*;

  localparam int CW = 32;
  localparam int W  = 1 + 9 + CW;
  // Control word order: pc_write pc_src ifid_write idex_bubble ifid_flush idex_flush exmem_flush pipe_freeze mem_err
  localparam logic [8:0] RUNO   = 9'b101000000;
  localparam logic [8:0] STALL  = 9'b000100000;
  localparam logic [8:0] FLUSH  = 9'b110011100;
  localparam logic [8:0] FREEZE = 9'b000000010;
  localparam logic [8:0] ERR    = 9'b000000001;
  localparam logic [8:0] ZERO   = 9'b000000000;

  typedef logic [23:0] stim_t;
  localparam stim_t IDLE = '0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus_b ();

  pipeline_hazard_ctrl #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(8), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  pipeline_hazard_ctrl #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  logic [8:0] ctl_a, ctl_b;
  assign ctl_a = {bus_a.pc_write, bus_a.pc_src, bus_a.ifid_write, bus_a.idex_bubble, bus_a.ifid_flush,
                  bus_a.idex_flush, bus_a.exmem_flush, bus_a.pipe_freeze, bus_a.mem_err};
  assign ctl_b = {bus_b.pc_write, bus_b.pc_src, bus_b.ifid_write, bus_b.idex_bubble, bus_b.ifid_flush,
                  bus_b.idex_flush, bus_b.exmem_flush, bus_b.pipe_freeze, bus_b.mem_err};

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [CW-1:0] sc_a, sc_b;

  // Stimulus word: memread rd[5] rs1[5] rs2[5] branch zero res_lsb funct3[3] memacc ready
  function automatic stim_t lu(input logic m, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {m, rd, rs1, rs2, 8'b0};
  endfunction

  function automatic stim_t br(input logic [2:0] f3, input logic z, input logic l);
    return {16'b0, 1'b1, z, l, f3, 2'b00};
  endfunction

  function automatic stim_t mw(input logic rdy);
    return {22'b0, 1'b1, rdy};
  endfunction

  task automatic drive(input bit sel, input stim_t s);
    stim_t sa, sb;
    sa = sel ? IDLE : s;
    sb = sel ? s : IDLE;
    bus_a.idex_memread = sa[23];  bus_a.idex_rd = sa[22:18];
    bus_a.ifid_rs1 = sa[17:13];   bus_a.ifid_rs2 = sa[12:8];
    bus_a.exmem_branch = sa[7];   bus_a.exmem_zero = sa[6];
    bus_a.exmem_res_lsb = sa[5];  bus_a.exmem_funct3 = sa[4:2];
    bus_a.exmem_memacc = sa[1];   bus_a.dmem_ready = sa[0];
    bus_b.idex_memread = sb[23];  bus_b.idex_rd = sb[22:18];
    bus_b.ifid_rs1 = sb[17:13];   bus_b.ifid_rs2 = sb[12:8];
    bus_b.exmem_branch = sb[7];   bus_b.exmem_zero = sb[6];
    bus_b.exmem_res_lsb = sb[5];  bus_b.exmem_funct3 = sb[4:2];
    bus_b.exmem_memacc = sb[1];   bus_b.dmem_ready = sb[0];
  endtask

  // One cycle of stimulus for the selected instance; expected counter value is
  // the number of earlier cycles whose expected pc_write was 0.
  task automatic step(input bit sel, input bit rst, input stim_t s, input logic [8:0] ctl, input string name);
    @(posedge clk);
    #1;
    reset = rst;
    drive(sel, s);
    if (rst) begin
      sc_a = '0;
      sc_b = '0;
    end
    exp_q.push_back({sel, ctl, sel ? sc_b : sc_a});
    name_q.push_back(name);
    if (!rst && !ctl[8]) begin
      if (sel) sc_b = sc_b + 1;
      else     sc_a = sc_a + 1;
    end
  endtask

  initial begin
    logic [W-1:0]  e;
    string         n;
    logic [8:0]    act_ctl;
    logic [CW-1:0] act_sc;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        act_ctl = e[W-1] ? ctl_b : ctl_a;
        act_sc  = e[W-1] ? bus_b.stall_cycles : bus_a.stall_cycles;
        checks++;
        if (act_ctl !== e[W-2 -: 9]) begin
          errors++;
          $display("FAIL %s ctl: got %b want %b", n, act_ctl, e[W-2 -: 9]);
        end
        checks++;
        if (act_sc !== e[CW-1:0]) begin
          errors++;
          $display("FAIL %s stall_cycles: got %0d want %0d", n, act_sc, e[CW-1:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    sc_a  = '0;
    sc_b  = '0;
    drive(1'b0, IDLE);

    step(0, 1, IDLE, ZERO, "reset_a");
    step(1, 1, IDLE, ZERO, "reset_b");

    step(0, 0, IDLE, RUNO, "a_idle");
    step(0, 0, lu(1, 5, 0, 5), STALL, "a_lu_rs2");
    step(0, 0, IDLE, RUNO, "a_lu_done");
    step(0, 0, lu(1, 0, 0, 3), RUNO, "a_x0_filter");
    step(0, 0, lu(0, 7, 7, 0), RUNO, "a_noload_filter");
    step(0, 0, lu(1, 5, 5, 0), STALL, "a_lu_rs1");
    step(0, 0, br(F3_BEQ, 1, 0), FLUSH, "a_beq_taken");
    step(0, 0, IDLE, RUNO, "a_flush_one_cycle");
    step(0, 0, br(F3_BNE, 1, 0), RUNO, "a_bne_not_taken");
    step(0, 0, br(F3_BGE, 0, 0), FLUSH, "a_bge_taken");
    step(0, 0, br(F3_BLT, 0, 1), FLUSH, "a_blt_taken");
    step(0, 0, br(F3_BLTU, 0, 0), RUNO, "a_bltu_not_taken");
    step(0, 0, br(3'b010, 1, 1), RUNO, "a_f3_010_never");
    step(0, 0, br(F3_BEQ, 1, 0) | lu(1, 5, 5, 5), FLUSH, "a_branch_over_lu");

    for (int i = 1; i <= 4; i++) step(0, 0, mw(0), FREEZE, $sformatf("a_memwait_%0d", i));
    step(0, 0, mw(1), RUNO, "a_mem_release");
    step(0, 0, IDLE, RUNO, "a_after_release");

    step(0, 0, mw(0) | br(F3_BEQ, 1, 0), FREEZE, "a_prio_freeze_only");
    step(0, 0, mw(1) | br(F3_BEQ, 1, 0), RUNO, "a_release_ignores_branch");
    step(0, 0, br(F3_BEQ, 1, 0), FLUSH, "a_branch_reeval");
    step(0, 0, IDLE, RUNO, "a_idle2");

    for (int i = 1; i <= 10; i++)
      step(0, 0, mw(0), FREEZE | ((i >= 9) ? ERR : ZERO), $sformatf("a_timeout_%0d", i));
    step(0, 0, mw(1), RUNO | ERR, "a_timeout_release");
    step(0, 0, IDLE, RUNO | ERR, "a_err_sticky1");
    step(0, 0, lu(1, 3, 3, 0), STALL | ERR, "a_err_sticky2");
    step(0, 0, IDLE, RUNO | ERR, "a_err_sticky3");

    step(0, 1, IDLE, ZERO, "a_reset_clears_err");
    step(0, 0, IDLE, RUNO, "a_post_reset");

    step(1, 0, IDLE, RUNO, "b_idle");
    step(1, 0, lu(1, 9, 9, 0), STALL, "b_lu_1");
    step(1, 0, IDLE, STALL, "b_lu_2");
    step(1, 0, IDLE, STALL, "b_lu_3");
    step(1, 0, IDLE, RUNO, "b_lu_done");
    step(1, 0, lu(1, 9, 0, 9), STALL, "b_lu2_1");
    step(1, 0, IDLE, STALL, "b_lu2_2");
    step(1, 1, IDLE, ZERO, "b_reset_mid_stall");
    step(1, 0, IDLE, RUNO, "b_run_after_reset");
    step(1, 0, IDLE, RUNO, "b_idle2");
    step(1, 0, lu(1, 4, 4, 4), STALL, "b_lu3_1");
    step(1, 0, br(F3_BEQ, 1, 0), FLUSH, "b_branch_preempts");
    step(1, 0, IDLE, RUNO, "b_lu_cleared");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage RISC-V pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards, resolves branches from the EX/MEM stage outputs and freezes the pipeline on data-memory wait.
- Drives write-enable, bubble and flush controls for every pipeline register and the PC-select mux.
- Keeps a sticky memory-timeout error and a saturating stall-cycle counter.

Parameters:
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- MEM_TIMEOUT, 255, consecutive dmem wait cycles before mem_err is set (1..65535).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- idex_memread  in  1  ID/EX MemRead.
- idex_rd  in  5  ID/EX destination register.
- ifid_rs1  in  5  IF/ID source register 1.
- ifid_rs2  in  5  IF/ID source register 2.
- exmem_branch  in  1  EX/MEM Branch_out.
- exmem_zero  in  1  EX/MEM ZERO_out.
- exmem_res_lsb  in  1  EX/MEM Result_out[0] (SLT/SLTU result).
- exmem_funct3  in  3  EX/MEM funct3_MEM.
- exmem_memacc  in  1  EX/MEM MemRead_out | MemWrite_out.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- pc_src  out  1  1 = select branch target (Adder_B_2).
- ifid_write  out  1  IF/ID load enable.
- idex_bubble  out  1  load zeros into ID/EX control fields.
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous clear of that stage register.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- mem_err  out  1  sticky timeout flag.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write = 0.

Behaviour:
- States: RUN, LU_STALL, MEM_WAIT. Reset state is RUN; reset clears lu_cnt, wait_cnt, mem_err and stall_cycles.
- While reset is high, all outputs are 0 (write enables are therefore 0).
- Control outputs are combinational from the current state and inputs; the state, counters and mem_err are registered.
- branch_taken = exmem_branch and the funct3-selected condition:
  - 000 beq: zero
  - 001 bne: !zero
  - 100 blt, 110 bltu: res_lsb
  - 101 bge, 111 bgeu: !res_lsb
  - 010, 011: never taken
- lu_hazard = idex_memread and idex_rd != 0 and (idex_rd == ifid_rs1 or idex_rd == ifid_rs2).
- mem_wait = exmem_memacc and !dmem_ready.
- Priority, highest first: mem_wait, then branch_taken, then lu_hazard.
- In RUN:
  - mem_wait: pipe_freeze = 1, pc_write = 0, ifid_write = 0, wait_cnt = 1, next state MEM_WAIT.
  - branch_taken: pc_src = 1, pc_write = 1, ifid_flush = idex_flush = exmem_flush = 1, stay in RUN.
  - lu_hazard: pc_write = 0, ifid_write = 0, idex_bubble = 1. If LU_STALL_CYCLES > 1, load lu_cnt = LU_STALL_CYCLES-1 and go to LU_STALL.
  - otherwise: pc_write = 1, ifid_write = 1, all other controls 0.
- In LU_STALL:
  - Same outputs as the lu_hazard case; lu_cnt decrements each cycle.
  - Go to RUN when lu_cnt reaches 0.
  - mem_wait preempts: go to MEM_WAIT and keep lu_cnt.
  - branch_taken preempts: flush and go to RUN, clearing lu_cnt.
- In MEM_WAIT:
  - Freeze outputs are held; wait_cnt increments and saturates.
  - When wait_cnt == MEM_TIMEOUT, set mem_err; it is cleared only by reset.
  - dmem_ready = 1: release the freeze that cycle. Go to LU_STALL if lu_cnt != 0, otherwise RUN.
  - Branch and load-use evaluation are ignored in the release cycle; they re-evaluate on the next cycle.
- stall_cycles increments every cycle with pc_write = 0 while out of reset, saturating at all-ones.
- An asynchronous reset mid-stall or mid-wait returns to RUN immediately; no partial outputs are asserted.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - state enum (RUN, LU_STALL, MEM_WAIT)
  - funct3 branch encodings (F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101, F3_BLTU=110, F3_BGEU=111)
  - register index width (5)
- One combinational sub-module, branch_resolve, computes branch_taken from branch, zero, res_lsb and funct3.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, ifid_rs2=5, LU_STALL_CYCLES=1 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1; back to RUN.
- x0 and no-load filter: idex_rd=0 with rs1=0, and separately idex_memread=0 with idex_rd=7=rs1 -> no stall asserted.
- Branches:
  - branch=1, funct3=000, zero=1 -> pc_src=1 and all three flushes asserted for exactly 1 cycle.
  - funct3=001, zero=1 -> no flush.
  - funct3=101, res_lsb=0 -> taken.
- Memory wait: exmem_memacc=1 with dmem_ready low for 4 cycles -> pipe_freeze=1 for 4 cycles, released in the cycle ready rises; mem_err=0.
- Timeout: MEM_TIMEOUT=8, ready held low for 10 cycles -> mem_err rises at the 8th wait cycle and stays set until reset.
- Priority and reset: mem_wait together with branch_taken -> freeze only, no flush. Reset asserted mid-LU_STALL (LU_STALL_CYCLES=3) -> all outputs 0 and stall_cycles=0 immediately; RUN after reset is released.
